obuft_bank_turnaround: RTL and testbench

- Parametrised, registered tri-state output bank: WIDTH pad bits driven from one output-data register under one shared enable.
- Adds a drive request/grant handshake with enforced hi-Z turnaround before driving and a minimum hi-Z hold after releasing, so no two drivers fight on a shared bidirectional bus.
- Global tri-state input (gts) overrides the pad drive immediately and forces the bank to release.
- Sits between core logic and the inout pads of a shared board-level bus; also returns a registered capture of the pad for the receive path.

---
 rtl/obuft_bank_turnaround_if.sv | 38 +++
 rtl/obuft_bank_turnaround.sv | 112 +++++++++++
 tb/tb_obuft_bank_turnaround.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/obuft_bank_turnaround_if.sv
// rtl/obuft_bank_turnaround_if.sv - core-side handshake and data bundle for the turnaround output bank
//
// Purpose: groups the core-facing signals of obuft_bank_turnaround.
// Signals:
//   gts      core -> bank  global tri-state, 1 forces the pad hi-Z
//   drv_req  core -> bank  level request to drive the pad
//   dout     core -> bank  data to drive (registered inside the bank)
//   drv_gnt  bank -> core  1 while the bank drives the pad
//   din      bank -> core  registered capture of the pad
//   busy     bank -> core  1 whenever the bank is not idle
interface obuft_bank_turnaround_if #(
    parameter int WIDTH = 8
);
    logic             gts;
    logic             drv_req;
    logic [WIDTH-1:0] dout;
    logic             drv_gnt;
    logic [WIDTH-1:0] din;
    logic             busy;

    modport master (
        output gts,
        output drv_req,
        output dout,
        input  drv_gnt,
        input  din,
        input  busy
    );

    modport slave (
        input  gts,
        input  drv_req,
        input  dout,
        output drv_gnt,
        output din,
        output busy
    );
endinterface

// File: rtl/obuft_bank_turnaround.sv
// rtl/obuft_bank_turnaround.sv - registered tri-state output bank with drive request/grant turnaround
//
// Purpose: drives WIDTH pad bits from one data register under a shared enable,
// inserting hi-Z turnaround cycles before driving and a hi-Z hold after
// releasing; gts forces the pad hi-Z immediately and ends any drive.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    core-side interface (gts, drv_req, dout in; drv_gnt, din, busy out)
//   pad    bidirectional pad bus
module obuft_bank_turnaround #(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    obuft_bank_turnaround_if.slave        bus,
    inout  wire  [WIDTH-1:0]              pad
);

    localparam int MAX_CNT = (TURN_CYCLES > HOLD_CYCLES) ? TURN_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = (MAX_CNT <= 1) ? 1 : $clog2(MAX_CNT);

    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TURN_ON  = 2'd1,
        DRIVE    = 2'd2,
        TURN_OFF = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_dout_q;
    logic [WIDTH-1:0] r_din;
    logic             w_drive;
    logic             w_busy;

    // State register; async reset releases the pad without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_dout_q <= '0;
            r_din    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dout_q <= bus.dout;
            r_din    <= pad;
        end
    end

    // Next state. gts outranks drv_req in every state except TURN_OFF,
    // where the hold time must complete regardless.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.drv_req && !bus.gts) begin
                    w_state_nxt = TURN_ON;
                    w_cnt_nxt   = '0;
                end
            end
            TURN_ON: begin
                if (!bus.drv_req || bus.gts) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == TURN_LAST) begin
                    w_state_nxt = DRIVE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DRIVE: begin
                if (!bus.drv_req || bus.gts) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (HOLD_CYCLES == 0) ? IDLE : TURN_OFF;
                end
            end
            TURN_OFF: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state only, so drv_gnt cannot glitch.
    always_comb begin
        w_drive = (r_state == DRIVE);
        w_busy  = (r_state != IDLE);
    end

    assign bus.drv_gnt = w_drive;
    assign bus.busy    = w_busy;
    assign bus.din     = r_din;

    // gts is deliberately combinational here so a board-level tri-state wins at once.
    assign pad = (w_drive && !bus.gts) ? r_dout_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_obuft_bank_turnaround.sv
// tb/tb_obuft_bank_turnaround.sv - self-checking bench for obuft_bank_turnaround
module tb_obuft_bank_turnaround;

    localparam int          TURN  = 2;
    localparam logic [7:0]  OTHER = 8'h81;

    logic       clk;
    logic       rst_n;
    logic       gts;
    logic       req;
    logic [7:0] dout;

    int checks = 0;
    int errors = 0;

    obuft_bank_turnaround_if #(.WIDTH(8)) ifc0 ();
    obuft_bank_turnaround_if #(.WIDTH(8)) ifc1 ();
    obuft_bank_turnaround_if #(.WIDTH(8)) ifc2 ();

    wire [7:0] pad0;
    wire [7:0] pad1;
    wire [7:0] pad2;

    assign ifc0.gts = gts;  assign ifc0.drv_req = req;  assign ifc0.dout = dout;
    assign ifc1.gts = gts;  assign ifc1.drv_req = req;  assign ifc1.dout = dout;
    assign ifc2.gts = gts;  assign ifc2.drv_req = req;  assign ifc2.dout = dout;

    obuft_bank_turnaround #(.WIDTH(8), .TURN_CYCLES(TURN), .HOLD_CYCLES(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .bus(ifc0.slave), .pad(pad0));
    obuft_bank_turnaround #(.WIDTH(8), .TURN_CYCLES(TURN), .HOLD_CYCLES(0)) u_h0 (
        .clk(clk), .rst_n(rst_n), .bus(ifc1.slave), .pad(pad1));
    obuft_bank_turnaround #(.WIDTH(8), .TURN_CYCLES(TURN), .HOLD_CYCLES(3)) u_h3 (
        .clk(clk), .rst_n(rst_n), .bus(ifc2.slave), .pad(pad2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: mode 0 idle, 1 waiting for grant, 2 driving, 3 holding hi-Z.
    // left = edges still to go before the next phase change.
    int         hold_of [3] = '{1, 0, 3};
    int         m_mode  [3];
    int         m_left  [3];
    logic [7:0] m_din   [3];
    logic [7:0] m_dq;
    logic [2:0] oe;

    function automatic logic [7:0] exp_pad(int i);
        return (m_mode[i] == 2 && !gts) ? m_dq : OTHER;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dq <= 8'h00;
            for (int i = 0; i < 3; i++) begin
                m_mode[i] <= 0;
                m_left[i] <= 0;
                m_din[i]  <= 8'h00;
            end
        end else begin
            m_dq <= dout;
            for (int i = 0; i < 3; i++) begin
                m_din[i] <= exp_pad(i);
                case (m_mode[i])
                    0: if (req && !gts) begin m_mode[i] <= 1; m_left[i] <= TURN; end
                    1: if (!req || gts) m_mode[i] <= 0;
                       else if (m_left[i] == 1) m_mode[i] <= 2;
                       else m_left[i] <= m_left[i] - 1;
                    2: if (!req || gts) begin
                           if (hold_of[i] == 0) m_mode[i] <= 0;
                           else begin m_mode[i] <= 3; m_left[i] <= hold_of[i]; end
                       end
                    default: if (m_left[i] == 1) m_mode[i] <= 0;
                             else m_left[i] <= m_left[i] - 1;
                endcase
            end
        end
    end

    // The other bus agent: drives OTHER whenever the bank must be hi-Z.
    always_comb begin
        for (int i = 0; i < 3; i++) oe[i] = !(m_mode[i] == 2 && !gts);
    end
    assign pad0 = oe[0] ? OTHER : 8'bzzzzzzzz;
    assign pad1 = oe[1] ? OTHER : 8'bzzzzzzzz;
    assign pad2 = oe[2] ? OTHER : 8'bzzzzzzzz;

    logic [7:0] d_pad  [3];
    logic [7:0] d_din  [3];
    logic       d_gnt  [3];
    logic       d_busy [3];
    always_comb begin
        d_pad[0] = pad0;  d_pad[1] = pad1;  d_pad[2] = pad2;
        d_din[0] = ifc0.din;  d_din[1] = ifc1.din;  d_din[2] = ifc2.din;
        d_gnt[0] = ifc0.drv_gnt;  d_gnt[1] = ifc1.drv_gnt;  d_gnt[2] = ifc2.drv_gnt;
        d_busy[0] = ifc0.busy;  d_busy[1] = ifc1.busy;  d_busy[2] = ifc2.busy;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("cyc gnt%0d", i),  32'(d_gnt[i]),  32'(m_mode[i] == 2));
                chk($sformatf("cyc busy%0d", i), 32'(d_busy[i]), 32'(m_mode[i] != 0));
                chk($sformatf("cyc pad%0d", i),  32'(d_pad[i]),  32'(exp_pad(i)));
                chk($sformatf("cyc din%0d", i),  32'(d_din[i]),  32'(m_din[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int  gap  [3];
    bit  done [3];
    int  want_gap [3] = '{4, 3, 6};

    initial begin
        rst_n = 1'b0; gts = 1'b0; req = 1'b0; dout = 8'hA5;
        #1;
        chk("rst gnt",  32'(ifc0.drv_gnt), 32'd0);
        chk("rst busy", 32'(ifc0.busy),    32'd0);
        chk("rst din",  32'(ifc0.din),     32'h00);
        chk("rst pad",  32'(pad0),         32'(OTHER));
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Grant latency: request seen at edge 0, grant after edge 2.
        dout = 8'h3C; req = 1'b1;
        tick();                                            // edge 0
        chk("lat e0 gnt", 32'(ifc0.drv_gnt), 32'd0);
        tick();                                            // edge 1
        chk("lat e1 gnt", 32'(ifc0.drv_gnt), 32'd0);
        chk("lat e1 pad", 32'(pad0), 32'(OTHER));
        tick();                                            // edge 2
        chk("lat e2 gnt", 32'(ifc0.drv_gnt), 32'd1);
        chk("lat e2 pad", 32'(pad0), 32'h3C);
        tick();                                            // edge 3
        chk("lat e3 din", 32'(ifc0.din), 32'h3C);
        tick();                                            // edge 4
        req = 1'b0;
        tick();                                            // edge 5
        chk("rel e5 pad", 32'(pad0), 32'(OTHER));
        chk("rel e5 gnt", 32'(ifc0.drv_gnt), 32'd0);
        tick();                                            // edge 6
        chk("rel e6 busy", 32'(ifc0.busy), 32'd0);
        repeat (4) tick();

        // Abort during turnaround.
        req = 1'b1;
        tick();
        chk("abort busy1", 32'(ifc0.busy), 32'd1);
        req = 1'b0;
        tick();
        chk("abort busy0", 32'(ifc0.busy), 32'd0);
        chk("abort gnt",   32'(ifc0.drv_gnt), 32'd0);
        repeat (2) tick();

        // gts override while driving.
        dout = 8'hFF; req = 1'b1;
        repeat (3) tick();
        chk("gts pre gnt", 32'(ifc0.drv_gnt), 32'd1);
        chk("gts pre pad", 32'(pad0), 32'hFF);
        #1 gts = 1'b1;
        #1;
        chk("gts async pad0", 32'(pad0), 32'(OTHER));
        chk("gts async pad2", 32'(pad2), 32'(OTHER));
        tick();
        chk("gts edge gnt",  32'(ifc0.drv_gnt), 32'd0);
        chk("gts edge busy", 32'(ifc0.busy),    32'd1);
        repeat (4) tick();
        chk("gts hold busy0", 32'(ifc0.busy), 32'd0);
        chk("gts hold busy2", 32'(ifc2.busy), 32'd0);
        gts = 1'b0;
        tick();
        chk("gts clr busy", 32'(ifc0.busy), 32'd1);
        repeat (2) tick();
        chk("b2b pre gnt1", 32'(ifc1.drv_gnt), 32'd1);

        // Back-to-back: drop for one edge, re-raise, measure hi-Z gap per instance.
        dout = 8'h5A;
        tick();
        req = 1'b0;
        tick();
        req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            gap[i]  = 1;
            done[i] = 1'b0;
        end
        for (int c = 0; c < 12; c++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                if (!done[i]) begin
                    if (d_gnt[i]) done[i] = 1'b1;
                    else gap[i]++;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("gap h%0d", hold_of[i]), 32'(gap[i]), 32'(want_gap[i]));
        end
        chk("b2b pad", 32'(pad2), 32'h5A);
        chk("b2b din", 32'(ifc2.din), 32'h5A);

        // Asynchronous reset mid-drive.
        dout = 8'hA5;
        tick(); tick();
        chk("pre rst pad", 32'(pad0), 32'hA5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst pad",  32'(pad0), 32'(OTHER));
        chk("arst gnt",  32'(ifc0.drv_gnt), 32'd0);
        chk("arst busy", 32'(ifc0.busy), 32'd0);
        chk("arst din",  32'(ifc0.din), 32'h00);
        req = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
